tx_message_selector: RTL

- Transmit-side counterpart of the receive acceptance filter.
- Selects the next 128-bit CAN message from either the TX high-priority buffer (HPB) or the TX FIFO and latches it into a holding register.
- Presents it to the bit-stream transmitter with a request/ack handshake.
- Retransmits on arbitration loss or bus error until success or until the retry limit is reached.

---
 rtl/tx_message_selector.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/tx_message_selector.sv
// TX message selector: picks the next message from the high-priority buffer
// or the TX FIFO, holds it, and drives the transmitter request/ack handshake
// with retransmission on arbitration loss or bus error.
module tx_message_selector #(
  parameter int unsigned MSG_W     = 128,
  parameter int unsigned MAX_RETRY = 16,
  parameter int unsigned RETRY_W   = 5
) (
  input  logic               i_sys_clk,
  input  logic               i_reset,
  input  logic               i_tx_fifo_empty,
  output logic               o_tx_fifo_r_en,
  input  logic [MSG_W-1:0]   i_tx_fifo_r_data,
  input  logic               i_hpb_valid,
  input  logic [MSG_W-1:0]   i_hpb_data,
  output logic               o_hpb_clear,
  output logic [MSG_W-1:0]   o_tx_message,
  output logic               o_tx_req,
  input  logic               i_tx_ack,
  input  logic               i_tx_done,
  input  logic               i_arb_lost,
  input  logic               i_tx_error,
  output logic               o_tx_success,
  output logic               o_tx_fail,
  output logic               o_txbsy,
  output logic [RETRY_W-1:0] o_retry_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FIFO_WAIT = 2'd1,
    REQUEST   = 2'd2,
    ACTIVE    = 2'd3
  } state_e;

  localparam logic [RETRY_W-1:0] CNT_MAX   = {RETRY_W{1'b1}};
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);
  localparam logic               LIMITED   = (MAX_RETRY != 0);

  state_e               state_q, state_d;
  logic [MSG_W-1:0]     msg_q, msg_d;
  logic [RETRY_W-1:0]   retry_cnt_q, retry_cnt_d;
  logic                 tx_req_q, tx_req_d;
  logic                 success_q, success_d;
  logic                 fail_q, fail_d;
  logic                 busy_q, busy_d;
  logic                 r_en_c;
  logic                 hpb_clear_c;

  logic [RETRY_W-1:0]   retry_inc;
  logic                 attempt_bad;
  logic                 limit_hit;

  // Failed-attempt bookkeeping shared by next-state and output logic
  always_comb begin
    retry_inc   = (retry_cnt_q == CNT_MAX) ? retry_cnt_q : retry_cnt_q + RETRY_W'(1);
    attempt_bad = i_arb_lost | i_tx_error;
    limit_hit   = LIMITED && (retry_inc == RETRY_LIM);
  end

  // State register
  always_ff @(posedge i_sys_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; HPB has priority in IDLE, done beats a same-cycle error
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_hpb_valid) begin
          state_d = REQUEST;
        end else if (!i_tx_fifo_empty) begin
          state_d = FIFO_WAIT;
        end
      end
      FIFO_WAIT: state_d = REQUEST;
      REQUEST: begin
        if (i_tx_ack) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (i_tx_done) begin
          state_d = IDLE;
        end else if (attempt_bad) begin
          state_d = limit_hit ? IDLE : REQUEST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; FIFO read and HPB clear are same-cycle strobes
  always_comb begin
    msg_d       = msg_q;
    retry_cnt_d = retry_cnt_q;
    success_d   = 1'b0;
    fail_d      = 1'b0;
    tx_req_d    = (state_d == REQUEST);
    busy_d      = (state_d != IDLE);
    r_en_c      = 1'b0;
    hpb_clear_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_hpb_valid) begin
          msg_d       = i_hpb_data;
          retry_cnt_d = '0;
          hpb_clear_c = 1'b1;
        end else if (!i_tx_fifo_empty) begin
          r_en_c = 1'b1;
        end
      end
      FIFO_WAIT: begin
        msg_d       = i_tx_fifo_r_data;
        retry_cnt_d = '0;
      end
      ACTIVE: begin
        if (i_tx_done) begin
          success_d = 1'b1;
        end else if (attempt_bad) begin
          retry_cnt_d = retry_inc;
          fail_d      = limit_hit;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and holding register
  always_ff @(posedge i_sys_clk or negedge i_reset) begin
    if (!i_reset) begin
      msg_q       <= '0;
      retry_cnt_q <= '0;
      tx_req_q    <= 1'b0;
      success_q   <= 1'b0;
      fail_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      msg_q       <= msg_d;
      retry_cnt_q <= retry_cnt_d;
      tx_req_q    <= tx_req_d;
      success_q   <= success_d;
      fail_q      <= fail_d;
      busy_q      <= busy_d;
    end
  end

  // Strobes are forced low while reset is held so every output reads 0 in reset
  assign o_tx_fifo_r_en = r_en_c & i_reset;
  assign o_hpb_clear    = hpb_clear_c & i_reset;
  assign o_tx_message   = msg_q;
  assign o_retry_cnt    = retry_cnt_q;
  assign o_tx_req       = tx_req_q;
  assign o_tx_success   = success_q;
  assign o_tx_fail      = fail_q;
  assign o_txbsy        = busy_q;

endmodule
